// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters/clear control and the register-file write arbiter.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              clr_start;
   logic              clr_busy;
   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] data0;
   logic              gnt0;
   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] data1;
   logic              gnt1;
   logic [ADDR_W-1:0] rf_w_addr;
   logic [DATA_W-1:0] rf_w_data;
   logic              write_reg;

   modport master (
      output clr_start, req0, addr0, data0, req1, addr1, data1,
      input  clr_busy, gnt0, gnt1, rf_w_addr, rf_w_data, write_reg
   );

   modport slave (
      input  clr_start, req0, addr0, data0, req1, addr1, data1,
      output clr_busy, gnt0, gnt1, rf_w_addr, rf_w_data, write_reg
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port with a full-file clear sweep.
// One write per cycle at most; write address/data/enable are registered.
module regfile_write_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int NREG   = 2**ADDR_W
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   regfile_write_arbiter_if.slave bus
);
   typedef enum logic {IDLE, CLEAR} state_e;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

   state_e            state_q;
   logic              ptr_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              gnt0, gnt1;

   // Grants are combinational; a clear request in the same cycle wins over both requesters.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_ni && state_q == IDLE && !bus.clr_start) begin
         if (bus.req0 && bus.req1) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
         end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wr_q <= 1'b0;
               if (bus.clr_start) begin
                  // Address 0 goes out on the entry edge; cnt_q holds the next address.
                  state_q <= CLEAR;
                  wr_q    <= 1'b1;
                  addr_q  <= '0;
                  data_q  <= '0;
                  cnt_q   <= ADDR_W'(1);
               end else if (gnt0) begin
                  wr_q   <= 1'b1;
                  addr_q <= bus.addr0;
                  data_q <= bus.data0;
                  ptr_q  <= 1'b1;
               end else if (gnt1) begin
                  wr_q   <= 1'b1;
                  addr_q <= bus.addr1;
                  data_q <= bus.data1;
                  ptr_q  <= 1'b0;
               end
            end
            CLEAR: begin
               if (addr_q == LAST) begin
                  state_q <= IDLE;
                  wr_q    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  addr_q <= cnt_q;
                  cnt_q  <= cnt_q + ADDR_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.clr_busy  = (state_q == CLEAR);
   assign bus.write_reg = wr_q;
   assign bus.rf_w_addr = addr_q;
   assign bus.rf_w_data = data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table for grants, scoreboard queue for the write port.
module tb_regfile_write_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREG(32)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic          r0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          r1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          clr;
      logic          g0;
      logic          g1;
      logic          busy;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            due;
   } wr_t;

   wr_t  q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   vec_t tbl[10];
   wr_t  mon_w;
   logic mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic clr, input logic g0, input logic g1, input logic busy);
      vec_t v;
      v.r0 = r0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.a1 = a1; v.d1 = d1;
      v.clr = clr; v.g0 = g0; v.g1 = g1; v.busy = busy;
      return v;
   endfunction

   // Scoreboard consumer: each expected write must appear exactly in its due cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         mon_exp = (q.size() > 0) && (q[0].due == cyc);
         chk("write_reg", 64'(bus.write_reg), 64'(mon_exp));
         if (mon_exp) begin
            mon_w = q.pop_front();
            if (bus.write_reg) begin
               chk("rf_w_addr", 64'(bus.rf_w_addr), 64'(mon_w.a));
               chk("rf_w_data", 64'(bus.rf_w_data), 64'(mon_w.d));
            end
         end
      end
   end

   // Drive one cycle of stimulus, push the expected write(s), then check grants and busy.
   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.req0      = v.r0;
      bus.addr0     = v.a0;
      bus.data0     = v.d0;
      bus.req1      = v.r1;
      bus.addr1     = v.a1;
      bus.data1     = v.d1;
      bus.clr_start = v.clr;
      if (v.g0)      q.push_back('{v.a0, v.d0, cyc + 1});
      else if (v.g1) q.push_back('{v.a1, v.d1, cyc + 1});
      if (v.clr && !v.busy)
         for (int i = 0; i < 32; i++) q.push_back('{AW'(i), '0, cyc + 1 + i});
      @(negedge clk);
      chk("gnt0", 64'(bus.gnt0), 64'(v.g0));
      chk("gnt1", 64'(bus.gnt1), 64'(v.g1));
      chk("clr_busy", 64'(bus.clr_busy), 64'(v.busy));
   endtask

   initial begin
      tbl[0] = mk(1, 5'd11, 32'hA5A5_00FF, 0, 5'd0, 32'h0, 0, 1, 0, 0);
      tbl[1] = mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h1111_1111, 0, 0, 1, 0);
      tbl[2] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
      for (int i = 3; i < 7; i++)
         tbl[i] = mk(1, AW'(i), 32'hD000_0000 + 32'(i), 1, AW'(16 + i), 32'hE000_0000 + 32'(i),
                     0, (i % 2 == 1), (i % 2 == 0), 0);
      tbl[7] = mk(1, 5'd3, 32'hCAFE_0007, 1, 5'd30, 32'hBEEF_0007, 0, 1, 0, 0);
      tbl[8] = mk(1, 5'd4, 32'hCAFE_0008, 0, 5'd0, 32'h0, 0, 1, 0, 0);
      tbl[9] = mk(1, 5'd5, 32'hCAFE_0009, 1, 5'd29, 32'hBEEF_0009, 0, 0, 1, 0);

      // Reset held with a request and a clear pending: everything must stay quiet.
      bus.req0 = 1'b1; bus.addr0 = 5'd11; bus.data0 = 32'hFFFF_FFFF;
      bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
      bus.clr_start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_write_reg", 64'(bus.write_reg), 64'd0);
      chk("rst_rf_w_addr", 64'(bus.rf_w_addr), 64'd0);
      chk("rst_rf_w_data", 64'(bus.rf_w_data), 64'd0);
      chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
      chk("rst_gnt0_clr", 64'(bus.gnt0), 64'd0);
      chk("rst_gnt1", 64'(bus.gnt1), 64'd0);
      bus.clr_start = 1'b0;
      #1;
      chk("rst_gnt0", 64'(bus.gnt0), 64'd0);

      // Table: single requesters, idle, alternating contention, pointer after single grant.
      for (int i = 0; i < 10; i++) step(tbl[i]);

      // Clear with Req1 raised in the same cycle and held; a second Clr_Start mid-sweep is ignored.
      step(mk(0, 5'd0, 32'h0, 1, 5'd9, 32'h9999_0001, 1, 0, 0, 0));
      for (int s = 0; s < 32; s++)
         step(mk(0, 5'd0, 32'h0, 1, 5'd9, 32'h9999_0001, (s == 5), 0, 0, 1));
      step(mk(0, 5'd0, 32'h0, 1, 5'd9, 32'h9999_0001, 0, 0, 1, 0));
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));

      // Second sweep aborted by reset while address 10 is on the write port.
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 0, 0));
      for (int s = 0; s < 11; s++)
         step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 1));
      chk("sweep_addr10", 64'(bus.rf_w_addr), 64'd10);
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("abort_write_reg", 64'(bus.write_reg), 64'd0);
      chk("abort_clr_busy", 64'(bus.clr_busy), 64'd0);
      chk("abort_rf_w_addr", 64'(bus.rf_w_addr), 64'd0);
      @(posedge clk);
      for (int s = 0; s < 3; s++)
         step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      step(mk(1, 5'd31, 32'h0123_4567, 0, 5'd0, 32'h0, 0, 1, 0, 0));
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));

      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
